// File: rtl/mac_seq_arb.sv
// mac_seq_arb: round-robin two-requester scheduler for a shared MAC; define MAC_SEQ_TIMEOUT_EN to add a stream stall watchdog
module mac_seq_arb #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8,
  parameter int MAC_LAT = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [2*LEN_W-1:0]   req_len,
  input  logic [1:0]           op_valid,
  output logic [1:0]           op_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [1:0]           res_valid,
  input  logic [1:0]           res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic                 res_err,
  output logic                 busy,
  output logic                 mac_rst_n,
  output logic                 mac_en,
  output logic [WIDTH/2-1:0]   mac_a,
  output logic [WIDTH/2-1:0]   mac_b,
  input  logic [WIDTH-1:0]     mac_out
);
  localparam int OW = WIDTH / 2;
  localparam int DW = $clog2(MAC_LAT + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic owner, ptr, gnt, hs, acc, timeout;
  logic [1:0] own_mask;
  logic [LEN_W-1:0] cnt, grant_len;
  logic [DW-1:0] dcnt;
  assign gnt = &req ? ptr : req[1];
  assign grant_len = gnt ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
  assign own_mask = owner ? 2'b10 : 2'b01;
  assign hs = state == STREAM && op_valid[owner];
  assign acc = state == DONE && res_ready[owner];
`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall;
  logic err;
  assign timeout = state == STREAM && !hs && stall == SW'(TIMEOUT - 1);
  assign res_err = err;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall <= '0;
      err <= 1'b0;
    end else begin
      stall <= (state == STREAM && !hs) ? stall + 1'b1 : '0;
      err <= timeout | (err & ~acc);
    end
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout = 1'b0;
  assign res_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|req) state_nxt = grant_len == '0 ? DONE : CLEAR;
      CLEAR: state_nxt = STREAM;
      STREAM: state_nxt = timeout ? DONE : (hs && cnt == LEN_W'(1)) ? DRAIN : STREAM;
      DRAIN: state_nxt = dcnt == DW'(1) ? DONE : DRAIN;
      DONE: if (acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // mac_rst_n is registered so the clear lands exactly on the CLEAR cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner <= 1'b0;
      ptr <= 1'b0;
      cnt <= '0;
      dcnt <= '0;
      res_data <= '0;
      mac_rst_n <= 1'b0;
    end else begin
      mac_rst_n <= state_nxt != CLEAR;
      if (state == IDLE && |req) begin
        owner <= gnt;
        cnt <= grant_len;
      end
      if (hs) cnt <= cnt - 1'b1;
      dcnt <= state == DRAIN ? dcnt - 1'b1 : DW'(MAC_LAT);
      if (timeout || (state == IDLE && |req && grant_len == '0)) res_data <= '0;
      else if (state == DRAIN && dcnt == DW'(1)) res_data <= mac_out;
      if (acc) ptr <= ~owner;
    end
  always_comb begin
    op_ready = state == STREAM ? own_mask : 2'b00;
    res_valid = state == DONE ? own_mask : 2'b00;
    mac_en = hs;
    mac_a = state == STREAM ? (owner ? op_a[WIDTH-1:OW] : op_a[OW-1:0]) : '0;
    mac_b = state == STREAM ? (owner ? op_b[WIDTH-1:OW] : op_b[OW-1:0]) : '0;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_mac_seq_arb.sv
// tb_mac_seq_arb: table, hand-written and random jobs against a dot-product / round-robin reference model
module tb_mac_seq_arb;
  localparam int W = 16, LW = 8, H = 8;
`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif
  logic clk = 0, reset = 1;
  logic [1:0] req = 0, op_valid = 0, res_ready = 0;
  logic [2*LW-1:0] req_len = 0;
  logic [W-1:0] op_a = 0, op_b = 0;
  logic [1:0] op_ready, res_valid;
  logic [W-1:0] res_data, mac_out;
  logic res_err, busy, mac_rst_n, mac_en;
  logic [H-1:0] mac_a, mac_b;
  int total = 0, bad = 0, ptr_m = 0;
  int ja[16], jb[16];
  typedef struct { int who; int len; logic [31:0] a; logic [31:0] b; int gap; int hold; int exp; } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  mac_seq_arb #(.WIDTH(W), .LEN_W(LW), .MAC_LAT(3), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .mac_rst_n(mac_rst_n), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_out(mac_out)
  );

  // shared MAC: operand register, product register, accumulator
  logic [H-1:0] s1a, s1b;
  logic s1v, s2v;
  logic [W-1:0] s2p, acc;
  always @(posedge clk) begin
    if (!mac_rst_n) begin
      s1v <= 0;
      s2v <= 0;
      acc <= 0;
    end else begin
      s1v <= mac_en;
      s1a <= mac_a;
      s1b <= mac_b;
      s2v <= s1v;
      s2p <= W'(s1a) * W'(s1b);
      if (s2v) acc <= acc + s2p;
    end
  end
  assign mac_out = acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] dot(input int n);
    int s = 0;
    for (int k = 0; k < n; k++) s += ja[k] * jb[k];
    return W'(s);
  endfunction

  task automatic arb_round(input logic [1:0] rq);
    int w;
    logic [1:0] own;
    w = (rq == 2'b11) ? ptr_m : (rq[1] ? 1 : 0);
    own = 2'(1 << w);
    req = rq;
    req_len = 0;
    @(negedge clk);
    #1;
    chk("arb_winner", {res_valid, res_data}, {own, 16'd0});
    res_ready = own;
    @(negedge clk);
    res_ready = 0;
    req = 0;
    #1;
    chk("arb_accepted", {res_valid, busy}, 3'b000);
    ptr_m = 1 - w;
  endtask

  task automatic run_job(input int r, input int n, input int gap, input int hold, input logic [W-1:0] exp);
    int k = 0, t = 0, lat = 1, en = 0, lows = 0;
    logic v;
    logic [1:0] own;
    own = 2'(1 << r);
    req = own;
    req_len = 0;
    req_len[r*LW +: LW] = LW'(n);
    @(negedge clk);
    req = 0;
    #1;
    if (n == 0) chk("len0_valid", {res_valid, mac_rst_n, mac_en}, {own, 2'b10});
    else begin
      chk("clear_pulse", {mac_rst_n, busy, op_ready}, 4'b0100);
      @(negedge clk);
      while (k < n && t < 200) begin
        v = gap != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
        op_valid = gap != 0 ? ~own : 2'b00;
        op_valid[r] = v;
        op_a = gap != 0 ? '1 : '0;
        op_b = op_a;
        op_a[r*H +: H] = H'(ja[k]);
        op_b[r*H +: H] = H'(jb[k]);
        res_ready = gap != 0 ? 2'b11 : 2'b00;
        #1;
        chk("stream_ready", op_ready, own);
        chk("mac_en", mac_en, v);
        if (v) begin
          chk("mac_ops", {mac_a, mac_b}, {H'(ja[k]), H'(jb[k])});
          k++;
        end
        lows += !mac_rst_n;
        t++;
        @(negedge clk);
      end
      chk("beats", k, n);
      op_valid = gap != 0 ? ~own : 2'b00;
      res_ready = gap != 0 ? ~own : 2'b00;
      #1;
      while (res_valid != own && lat < 20) begin
        en += mac_en;
        lows += !mac_rst_n;
        @(negedge clk);
        #1;
        lat++;
      end
      chk("latency", lat, 4);
      chk("quiet", en + lows, 0);
    end
    for (int h = 0; h < hold; h++) begin
      chk("hold", {res_valid, res_data}, {own, exp});
      @(negedge clk);
      #1;
    end
    chk("result", res_data, exp);
    chk("err", res_err, 0);
    res_ready = own;
    @(negedge clk);
    res_ready = 0;
    op_valid = 0;
    #1;
    chk("accepted", {res_valid, busy}, 3'b000);
    ptr_m = 1 - r;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 3, 32'h00010402, 32'h00010503, 0, 0, 27};
    tbl[1] = '{1, 4, 32'h0a0a0a0a, 32'h0a0a0a0a, 1, 5, 400};
    tbl[2] = '{0, 2, 32'h0000ffff, 32'h0000ffff, 0, 0, 64514};
    tbl[3] = '{1, 0, 32'h0, 32'h0, 0, 2, 0};
    tbl[4] = '{0, 1, 32'h7, 32'h9, 1, 1, 63};
    #2 reset = 0;
    #1;
    chk("reset_outs", {op_ready, res_valid, res_data, res_err, busy, mac_rst_n, mac_en}, 0);
    chk("reset_ops", {mac_a, mac_b}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1;
    chk("mac_rst_release", mac_rst_n, 1);
    arb_round(2'b11);
    arb_round(2'b10);
    arb_round(2'b11);
    arb_round(2'b11);
    for (int j = 0; j < 6; j++) arb_round(2'($urandom_range(1, 3)));
    foreach (tbl[i]) begin
      for (int k = 0; k < 4; k++) begin
        ja[k] = int'(tbl[i].a[k*8 +: 8]);
        jb[k] = int'(tbl[i].b[k*8 +: 8]);
      end
      run_job(tbl[i].who, tbl[i].len, tbl[i].gap, tbl[i].hold, W'(tbl[i].exp));
    end
    req = 2'b01;
    req_len = 16'd3;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    op_valid = 2'b01;
    op_a = 16'h0005;
    op_b = 16'h0005;
    @(negedge clk);
    op_valid = 0;
    #1;
    chk("mid_busy", {busy, op_ready}, 3'b101);
    reset = 0;
    #1;
    chk("mid_reset", {op_ready, res_valid, res_data, res_err, busy, mac_rst_n, mac_en}, 0);
    @(negedge clk);
    reset = 1;
    ptr_m = 0;
    @(negedge clk);
    ja[0] = 3;
    jb[0] = 3;
    run_job(0, 1, 0, 0, 16'd9);
    for (int j = 0; j < 20; j++) begin
      int r, n;
      r = $urandom_range(0, 1);
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        ja[k] = $urandom_range(0, 255);
        jb[k] = $urandom_range(0, 255);
      end
      run_job(r, n, $urandom_range(0, 1), $urandom_range(0, 2), dot(n));
    end
`ifdef MAC_SEQ_TIMEOUT_EN
    begin
      int lat;
      lat = 1;
      req = 2'b01;
      req_len = 16'd2;
      @(negedge clk);
      req = 0;
      @(negedge clk);
      op_valid = 2'b01;
      op_a = 16'h0004;
      op_b = 16'h0004;
      @(negedge clk);
      op_valid = 0;
      #1;
      while (res_valid != 2'b01 && lat < 30) begin
        @(negedge clk);
        #1;
        lat++;
      end
      chk("timeout_lat", lat, 9);
      chk("timeout_res", {res_err, res_data}, 17'h10000);
      res_ready = 2'b01;
      @(negedge clk);
      res_ready = 0;
      #1;
      chk("timeout_clr", {res_err, res_valid}, 0);
      ptr_m = 1;
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
